gcd_binary: RTL and testbench
=============================

// Module: gcd_binary
// PURPOSE
//  Parametrised multi-cycle GCD engine using the binary (Stein) algorithm.
//  Replaces the subtract-only GCD: one shift/subtract step per clock, so the
//  worst case is bounded at 2*W steps. Adds busy, zero-operand handling and a
//  step counter for latency profiling. Sits beside the arithmetic datapath
//  and is driven by a start/result_valid handshake.
// PARAMETERS
//  W      10               operand/result width in bits (>=2)
//  CNT_W  $clog2(2*W+1)    step-counter width (localparam, derived, not overridable)
//  K_W    $clog2(W)+1      common-power-of-two counter width (localparam)
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous reset, ACTIVE-LOW
//  start         in   1      request; sampled only when busy==0
//  A_in          in   W      operand A, captured on the accepted start edge
//  B_in          in   W      operand B, captured on the accepted start edge
//  busy          out  1      1 from the cycle after an accepted start until DONE
//  result        out  W      gcd(A,B); held until the next accepted start
//  result_valid  out  1      level; 1 while result holds a completed answer
//  steps         out  CNT_W  number of CALC steps that modified operands
// BEHAVIOUR
//  Reset (rst==0, async): state=IDLE, busy=0, result=0, result_valid=0,
//   steps=0, internal a/b/k=0. Reset mid-computation abandons it; no output.
//  States: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: start==1 at a rising edge: latch a=A_in, b=B_in, k=0, steps=0,
//   result_valid<=0. If A_in==0 or B_in==0 go to DONE, else go to CALC.
//  start while busy==1 (CALC/DONE): ignored, inputs not sampled.
//  CALC: exactly one action per clock, first match wins:
//   1 a==b        -> go DONE (no operand change, steps unchanged)
//   2 a,b even    -> a>>=1, b>>=1, k++, steps++
//   3 a even      -> a>>=1, steps++
//   4 b even      -> b>>=1, steps++
//   5 a>b         -> a=(a-b)>>1, steps++  (both odd: difference even, >=2)
//   6 else        -> b=(b-a)>>1, steps++
//   Subtraction is W-bit unsigned; the rule ordering guarantees no underflow.
//   a and b never reach 0 in CALC. steps<=2*W; k<=W-1.
//  DONE (one cycle): result = (a==0)? b : (b==0)? a : (a<<k), truncated to W
//   (cannot overflow: gcd<=max(A,B)); result_valid<=1; go IDLE.
//   gcd(0,0)=0 with result_valid=1; zero-operand cases give steps=0.
//  busy = (state==CALC || state==DONE). result_valid falls on the accepted
//   start edge and rises on the DONE->IDLE edge. start held high continuously
//   re-launches on the first IDLE cycle after each result, with the same
//   edge that raises result_valid not being an accept edge.
//  Latency: accepted start -> result_valid = steps+3 clocks for nonzero
//   operands (CALC steps + terminating compare + DONE); 2 clocks for zero.
// TESTING
//  1 rst low, then A=12,B=18, start 1 clk -> result=6, steps=3, valid 6 clks after.
//  2 A=752,B=168 -> result=8, valid held; then A=33,B=777 -> result=3.
//  3 A=0,B=45 -> result=45; A=45,B=0 -> 45; A=0,B=0 -> 0, valid=1, steps=0.
//  4 A=B=2**W-1 -> result=2**W-1, steps=0; A=2**(W-1),B=2**(W-2) -> 2**(W-2).
//  5 start pulsed while busy with different operands -> ignored, first result kept.
//  6 rst asserted mid-CALC -> busy, result, result_valid, steps all 0 immediately;
//    new start after release -> correct result; random sweep vs. $gcd model.

Source files
------------

// File: rtl/gcd_binary.sv
// Multi-cycle binary (Stein) GCD engine: one shift/subtract step per clock,
// start/result_valid handshake, plus a step counter for latency profiling.
module gcd_binary #(
    parameter  int W     = 10,
    localparam int CNT_W = $clog2(2*W+1),
    localparam int K_W   = $clog2(W)+1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     A_in,
    input  logic [W-1:0]     B_in,
    output logic             busy,
    output logic [W-1:0]     result,
    output logic             result_valid,
    output logic [CNT_W-1:0] steps
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [W-1:0]     a_q, b_q, a_d, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             busy_q, valid_q;
    logic [W-1:0]     result_q;
    logic             calc_done;
    logic [W-1:0]     diff;

    // a==0 / b==0 only occur for zero operands; otherwise a==b holds the odd part.
    function automatic logic [W-1:0] gcd_out(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [K_W-1:0] k);
        if (a == '0) return b;
        if (b == '0) return a;
        return a << k;
    endfunction

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        steps_d   = steps_q;
        calc_done = 1'b0;
        diff      = (a_q > b_q) ? (a_q - b_q) : (b_q - a_q);
        if (a_q == b_q) begin
            calc_done = 1'b1;
        end else if (!a_q[0] && !b_q[0]) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            k_d     = k_q + K_W'(1);
            steps_d = steps_q + CNT_W'(1);
        end else if (!a_q[0]) begin
            a_d     = a_q >> 1;
            steps_d = steps_q + CNT_W'(1);
        end else if (!b_q[0]) begin
            b_d     = b_q >> 1;
            steps_d = steps_q + CNT_W'(1);
        end else if (a_q > b_q) begin
            // Both odd, so the difference is even and the shift is exact.
            a_d     = diff >> 1;
            steps_d = steps_q + CNT_W'(1);
        end else begin
            b_d     = diff >> 1;
            steps_d = steps_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            steps_q  <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A_in;
                        b_q     <= B_in;
                        k_q     <= '0;
                        steps_q <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (A_in == '0 || B_in == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    k_q     <= k_d;
                    steps_q <= steps_d;
                    if (calc_done) state_q <= DONE;
                end
                DONE: begin
                    result_q <= gcd_out(a_q, b_q, k_q);
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign steps        = steps_q;

endmodule

// File: tb/tb_gcd_binary.sv
// Bench for gcd_binary: directed cases plus a random sweep against a
// Euclid/Stein-rule reference model.
module tb_gcd_binary;
    localparam int W     = 10;
    localparam int CNT_W = $clog2(2*W+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     A_in, B_in;
    logic             busy;
    logic [W-1:0]     result;
    logic             result_valid;
    logic [CNT_W-1:0] steps;

    int checks = 0;
    int errors = 0;

    gcd_binary #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A_in(A_in), .B_in(B_in),
        .busy(busy), .result(result), .result_valid(result_valid), .steps(steps)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: gcd via Euclid's remainder loop; step count from the
    // algorithm's rule list applied to plain integers.
    function automatic void model(input int a, input int b, output int g, output int st);
        int x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        g  = x;
        st = 0;
        if (a == 0 || b == 0) return;
        x = a; y = b;
        while (x != y) begin
            if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; end
            else if (x % 2 == 0) x /= 2;
            else if (y % 2 == 0) y /= 2;
            else if (x > y) x = (x - y) / 2;
            else y = (y - x) / 2;
            st++;
        end
    endfunction

    task automatic run(input string tag, input int a, input int b);
        int g, st, lat, guard;
        model(a, b, g, st);
        guard = 0;
        while (busy && guard < 200) begin @(negedge clk); guard++; end
        @(negedge clk);
        A_in = W'(a); B_in = W'(b); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        lat = 1;
        while (!result_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check({tag, "_result"}, result, g);
        check({tag, "_steps"}, steps, st);
        check({tag, "_latency"}, lat, (a == 0 || b == 0) ? 2 : st + 3);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; A_in = '0; B_in = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_steps", steps, 0);
        @(negedge clk); rst = 1'b1;

        run("t1_12_18", 12, 18);
        run("t2_752_168", 752, 168);
        repeat (3) @(negedge clk);
        check("t2_valid_held", result_valid, 1);
        check("t2_result_held", result, 8);
        run("t2_33_777", 33, 777);

        run("t3_0_45", 0, 45);
        run("t3_45_0", 45, 0);
        run("t3_0_0", 0, 0);
        check("t3_0_0_valid", result_valid, 1);

        run("t4_max", 2**W - 1, 2**W - 1);
        run("t4_pow2", 2**(W-1), 2**(W-2));

        // Start pulsed while busy with different operands must be ignored.
        @(negedge clk);
        A_in = 10'd12; B_in = 10'd18; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A_in = 10'd5; B_in = 10'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !result_valid; i++) @(negedge clk);
        check("t5_ignored_result", result, 6);
        check("t5_ignored_steps", steps, 3);
        repeat (2) @(negedge clk);
        check("t5_no_relaunch", busy, 0);

        // Start held high re-launches on the first IDLE cycle after a result.
        @(negedge clk);
        A_in = 10'd12; B_in = 10'd18; start = 1'b1;
        for (int i = 0; i < 40 && !result_valid; i++) begin @(posedge clk); #1; end
        check("t5b_hold_valid", result_valid, 1);
        check("t5b_hold_idle", busy, 0);
        @(posedge clk); #1;
        check("t5b_relaunch_busy", busy, 1);
        check("t5b_relaunch_valid", result_valid, 0);
        start = 1'b0;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);

        // Asynchronous reset mid-computation.
        @(negedge clk);
        A_in = 10'd1023; B_in = 10'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_result", result, 0);
        check("t6_rst_valid", result_valid, 0);
        check("t6_rst_steps", steps, 0);
        @(negedge clk); rst = 1'b1;
        run("t6_after_rst", 12, 18);

        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = $urandom_range(0, 2**W - 1);
            b = $urandom_range(0, 2**W - 1);
            if (i % 10 == 3) a = 0;
            if (i % 10 == 7) b = 0;
            run("rand", a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
